data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the CPU memory interface: accepts load/store requests from the multi-cycle core and returns read data or a store acknowledge after a fixed, parameterised latency.
- Word-organised on-chip RAM with byte/halfword/word access, sign/zero extension and misalignment detection.
- Sits beside the core and serves its fetch and load/store stages.
- Strictly one outstanding transaction, so the core's state machine can stall on the handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- LATENCY, 2, cycles from request acceptance to RESP_VALID; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- REQ_VALID  in  1  request present
- REQ_READY  out  1  responder can accept a request
- REQ_WE  in  1  1=store, 0=load
- REQ_FUNCT3  in  3  RISC-V width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, right-aligned
- RESP_VALID  out  1  response present
- RESP_READY  in  1  requester accepts response
- RESP_RDATA  out  32  extended load data; 0 for stores and errors
- RESP_ERR  out  1  misaligned address or illegal funct3

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE, REQ_READY=1, RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0, latency counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, the request is accepted. All request fields are latched into a request register.
  - Counter is loaded with LATENCY-1.
  - Next state is WAIT. If LATENCY=1, next state is RESP directly.
- WAIT:
  - REQ_READY=0. Counter decrements each cycle.
  - When the counter reaches 0, the access is performed on that edge and the state moves to RESP.
- Access performed (single edge):
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Store writes only the selected byte lanes (lane = addr[1:0]) from REQ_WDATA's low byte/halfword/word.
  - Load selects the byte/halfword at addr[1:0].
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW returns the word unchanged.
  - Results are registered into RESP_RDATA/RESP_ERR.
- Error conditions:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - funct3 011/110/111, or a store with funct3 bit2=1.
  - On error: no RAM write, RESP_RDATA=0, RESP_ERR=1.
- RESP:
  - RESP_VALID=1; RESP_RDATA and RESP_ERR are held stable until the handshake.
  - On RESP_READY the state returns to IDLE and RESP_VALID drops on the next edge.
  - Stores also produce a response (RDATA=0, ERR per checks).
- Total latency: response visible LATENCY cycles after the acceptance edge. If RESP_READY=1, the next request can be accepted one cycle after the response handshake (no same-cycle turnaround).
- REQ_VALID outside IDLE is ignored. The requester must hold the request until REQ_READY is sampled high.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Reset mid-operation: state returns to IDLE. A store still in WAIT is discarded (never written). A store already in RESP has been committed.

Decomposition:
- Shared package (existing def.sv):
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Typedef mem_req_t {we, funct3, addr, wdata}.
  - Enum for the FSM states.
- One combinational sub-module, load_store_align:
  - Inputs: funct3, addr[1:0], stored word, wdata.
  - Outputs: 4-bit byte-enable, shifted write word, extended read data, misalign/illegal flag.
- The top holds the FSM, counter, RAM array and response registers.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> RESP_RDATA=0xDEADBEEF, ERR=0; each RESP_VALID exactly LATENCY cycles after acceptance.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- LW 0x11 and LH 0x13 -> ERR=1, RDATA=0; a following LW 0x10 returns unchanged data, proving no write on a misaligned SW 0x12.
- RESP_READY held 0 for 5 cycles -> RESP_VALID and RDATA stable, REQ_READY=0, a second REQ_VALID is not accepted; it is accepted the cycle after the handshake.
- Assert RST during WAIT of SW 0x20 data 0xA5A5A5A5 (prior content 0) -> outputs at reset values immediately; afterwards LW 0x20 -> 0x00000000. Address 0x20+DEPTH_WORDS*4 aliases to 0x20.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: RISC-V width codes,
// the latched request record and the FSM state encoding.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
  );
endinterface

// File: rtl/data_mem_responder_load_store_align.sv
// Byte-lane steering for stores and extraction/extension for loads, plus
// misalignment and illegal-width detection. Purely combinational.
module load_store_align
  import data_mem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{addr_lo, 3'b000} +: 8];
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    be    = '0;
    wword = '0;
    rdata = '0;
    err   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      F3_H, F3_HU: begin
        err   = addr_lo[0];
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        err   = |addr_lo;
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: err = 1'b1;
    endcase
    // unsigned widths exist only for loads
    if (we && funct3[2]) err = 1'b1;
    if (err) be = '0;
    if (err || we) rdata = '0;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accepts one request, performs the
// RAM access LATENCY-1 edges later and holds the response until taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  data_mem_responder_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  IDLE     = ST_IDLE;
  localparam logic [1:0]  WAIT     = ST_WAIT;
  localparam logic [1:0]  RESP     = ST_RESP;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  mem_req_t      req_q, req_in, acc;
  logic          accept, go;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;
  logic [AW-1:0] widx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [3:0]    al_be;
  logic [31:0]   al_wword, al_rdata;
  logic          al_err;
  logic          unused_addr_hi;

  assign req_in = '{we: bus.REQ_WE, funct3: bus.REQ_FUNCT3,
                    addr: bus.REQ_ADDR, wdata: bus.REQ_WDATA};
  assign accept = (state == IDLE) && bus.REQ_VALID;

  // With LATENCY=1 the access happens on the acceptance edge, straight from the bus.
  assign go  = ((state == WAIT) && (cnt == 4'd1)) || (accept && (LATENCY == 1));
  assign acc = (state == IDLE) ? req_in : req_q;

  // Upper address bits only alias; they never select storage.
  assign widx           = acc.addr[AW+1:2];
  assign unused_addr_hi = ^acc.addr[31:AW+2];

  load_store_align u_align (
    .we      (acc.we),
    .funct3  (acc.funct3),
    .addr_lo (acc.addr[1:0]),
    .rword   (mem[widx]),
    .wdata   (acc.wdata),
    .be      (al_be),
    .wword   (al_wword),
    .rdata   (al_rdata),
    .err     (al_err)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      req_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.REQ_VALID) begin
          req_q <= req_in;
          cnt   <= CNT_INIT;
          state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (bus.RESP_READY) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go) begin
        resp_rdata_q <= al_rdata;
        resp_err_q   <= al_err;
      end
    end
  end

  // RAM has no reset; the RST gate keeps a held-reset acceptance from writing.
  always_ff @(posedge CLK) begin
    if (!RST && go && acc.we) begin
      for (int i = 0; i < 4; i++)
        if (al_be[i]) mem[widx][8*i +: 8] <= al_wword[8*i +: 8];
    end
  end

  assign bus.REQ_READY  = (state == IDLE);
  assign bus.RESP_VALID = (state == RESP);
  assign bus.RESP_RDATA = resp_rdata_q;
  assign bus.RESP_ERR   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic clk, rst;
  int   checks, errors;
  logic [7:0] mref [DEPTH*4];

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Little-endian byte memory: the architectural view of a load/store.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int sz, base;
    logic [31:0] v;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e    = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || ((a % sz) != 0);
    base = int'(a % (DEPTH*4));
    d    = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mref[base+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mref[base+i];
        if (!f3[2] && sz < 4 && v[8*sz-1])
          for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
        d = v;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.REQ_VALID  = 1'b1;
    bus.REQ_WE     = we;
    bus.REQ_FUNCT3 = f3;
    bus.REQ_ADDR   = a;
    bus.REQ_WDATA  = wd;
  endtask

  // From the acceptance edge: count negedges until RESP_VALID, then capture.
  task automatic await_resp(output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.RESP_VALID && n < 40);
    chk("latency", n, LAT);
    rd = bus.RESP_RDATA;
    er = bus.RESP_ERR;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    drive(we, f3, a, wd);
    n = 0;
    while (!bus.REQ_READY && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.REQ_VALID = 1'b0;
    await_resp(rd, er);
    bus.RESP_READY = 1'b1;
    @(posedge clk);
    #1 bus.RESP_READY = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] exp_d;
    logic        exp_e, er;
    model(we, f3, a, wd, exp_d, exp_e);
    txn(we, f3, a, wd, rd, er);
    chk({tag, "_rdata"}, rd, exp_d);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
  endtask

  initial begin
    logic [31:0] rd, snap, exp_d, a;
    logic        er, exp_e, we;
    logic [2:0]  f3;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_FUNCT3 = '0;
    bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.RESP_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.REQ_READY}, 1);
    chk("rst_resp_valid", {31'b0, bus.RESP_VALID}, 0);
    chk("rst_rdata", bus.RESP_RDATA, 0);
    chk("rst_err", {31'b0, bus.RESP_ERR}, 0);
    rst = 1'b0;

    // Known contents everywhere so random loads have a defined expectation.
    for (int i = 0; i < DEPTH; i++) run("init", 1'b1, 3'b010, 32'(i*4), $urandom, rd);

    run("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    run("lw_10", 1'b0, 3'b010, 32'h10, 0, rd);   chk("lw_10_const", rd, 32'hDEADBEEF);
    run("lb_13", 1'b0, 3'b000, 32'h13, 0, rd);   chk("lb_13_const", rd, 32'hFFFFFFDE);
    run("lbu_13", 1'b0, 3'b100, 32'h13, 0, rd);  chk("lbu_13_const", rd, 32'h000000DE);
    run("lh_10", 1'b0, 3'b001, 32'h10, 0, rd);   chk("lh_10_const", rd, 32'hFFFFBEEF);
    run("lhu_12", 1'b0, 3'b101, 32'h12, 0, rd);  chk("lhu_12_const", rd, 32'h0000DEAD);
    run("sb_11", 1'b1, 3'b000, 32'h11, 32'h55, rd);
    run("lw_10b", 1'b0, 3'b010, 32'h10, 0, rd);  chk("lw_sb_const", rd, 32'hDEAD55EF);
    run("sh_12", 1'b1, 3'b001, 32'h12, 32'h1234, rd);
    run("lw_10c", 1'b0, 3'b010, 32'h10, 0, rd);  chk("lw_sh_const", rd, 32'h123455EF);
    run("lw_11", 1'b0, 3'b010, 32'h11, 0, rd);
    run("lh_13", 1'b0, 3'b001, 32'h13, 0, rd);
    run("sw_12_mis", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, rd);
    run("sbu_ill", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd);
    run("f3_111", 1'b0, 3'b111, 32'h10, 0, rd);
    run("lw_10d", 1'b0, 3'b010, 32'h10, 0, rd);  chk("lw_nowrite_const", rd, 32'h123455EF);

    // Response stall: output held, second request ignored until after handshake.
    model(1'b0, 3'b010, 32'h10, 0, exp_d, exp_e);
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h10, 0);
    @(posedge clk);
    #1 drive(1'b0, 3'b010, 32'h14, 0);
    await_resp(snap, er);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, bus.RESP_VALID}, 1);
      chk("stall_rdata", bus.RESP_RDATA, exp_d);
      chk("stall_req_ready", {31'b0, bus.REQ_READY}, 0);
    end
    bus.RESP_READY = 1'b1;
    @(posedge clk);
    #1 bus.RESP_READY = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", {31'b0, bus.RESP_VALID}, 0);
    chk("post_hs_req_ready", {31'b0, bus.REQ_READY}, 1);
    model(1'b0, 3'b010, 32'h14, 0, exp_d, exp_e);
    @(posedge clk);
    #1 bus.REQ_VALID = 1'b0;
    await_resp(rd, er);
    chk("second_req_rdata", rd, exp_d);
    bus.RESP_READY = 1'b1;
    @(posedge clk);
    #1 bus.RESP_READY = 1'b0;

    // Reset while a store waits: the store must never land.
    run("sw_20_zero", 1'b1, 3'b010, 32'h20, 32'h0, rd);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
    @(posedge clk);
    #1 bus.REQ_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", {31'b0, bus.REQ_READY}, 1);
    chk("midrst_resp_valid", {31'b0, bus.RESP_VALID}, 0);
    chk("midrst_rdata", bus.RESP_RDATA, 0);
    chk("midrst_err", {31'b0, bus.RESP_ERR}, 0);
    @(negedge clk);
    rst = 1'b0;
    run("lw_20", 1'b0, 3'b010, 32'h20, 0, rd);   chk("lw_20_const", rd, 32'h0);
    run("sw_alias", 1'b1, 3'b010, 32'h20 + DEPTH*4, 32'hCAFEF00D, rd);
    run("lw_20b", 1'b0, 3'b010, 32'h20, 0, rd);  chk("alias_const", rd, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run("rand", we, f3, a, $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
